nx_seq_logic_node: RTL and testbench
====================================

// Module: nx_seq_logic_node
// PURPOSE
// - Programmable logic node for the mesh: runs a loaded sequence of 2-input boolean
//   instructions, one per cycle, over captured inputs and a local register file.
// - Publishes a registered output vector per run.
// - Parametrised, run-time-loadable successor to the statically generated per-node
//   gate netlists; one instance per mesh row/column.
// PARAMETERS
// - NUM_INPUTS   8   node input bits, captured at trigger
// - NUM_OUTPUTS  8   output bits; o_outputs[k] mirrors reg[k]; NUM_OUTPUTS <= NUM_REGS
// - NUM_REGS     16  working registers, 1 bit each
// - MAX_INSTRS   32  instruction memory depth; ADDR_W = $clog2(MAX_INSTRS)
// - Derived: SEL_W = $clog2(max(NUM_INPUTS,NUM_REGS)), REG_W = $clog2(NUM_REGS),
//   INSTR_W = 3 + 2*(1+SEL_W) + REG_W
// PORTS
// - clk          in   1            clock
// - rst_n        in   1            async reset, active low
// - i_ld_valid   in   1            instruction write strobe
// - i_ld_addr    in   ADDR_W       write address
// - i_ld_data    in   INSTR_W      {op[2:0], is_in_a, src_a, is_in_b, src_b, tgt}
// - o_ld_ready   out  1            write accepted this cycle (high only in IDLE)
// - i_prog_len   in   ADDR_W+1     instruction count, sampled on accepted trigger
// - i_trigger    in   1            start-run request
// - i_inputs     in   NUM_INPUTS   node inputs, sampled on accepted trigger
// - o_busy       out  1            run in progress (state != IDLE)
// - o_done       out  1            1-cycle pulse: o_outputs updated
// - o_outputs    out  NUM_OUTPUTS  registered results, held between runs
// BEHAVIOUR
// - Reset (async, rst_n=0): state=IDLE, pc=0, regs=0, in_q=0, imem=0, o_outputs=0,
//   o_done=0, o_busy=0, o_ld_ready=0 until first IDLE cycle after release.
// - Ops: 0 INVERT(a), 1 AND, 2 NAND, 3 OR, 4 NOR, 5 XOR, 6 XNOR, 7 NOP (no write).
// - Operand: is_in=1 -> in_q[src], else reg[src]; src >= limit reads 0.
// - Result written to reg[tgt] at clock edge.
// - FSM: IDLE -> EXEC on i_trigger with len>0; IDLE -> COMMIT on i_trigger with len=0.
//   EXEC -> COMMIT after instr len-1. COMMIT -> IDLE.
// - Trigger accepted at cycle T: in_q <= i_inputs, len_q <= min(i_prog_len, MAX_INSTRS).
// - EXEC: instr pc executes in cycle T+1+pc; later instrs see earlier results.
// - COMMIT edge: o_outputs <= reg[NUM_OUTPUTS-1:0], o_done <= 1.
// - Latency: o_done and o_outputs visible in cycle T+len+2 (T+2 for len=0).
// - i_trigger while busy: ignored, not queued.
// - i_trigger in the o_done cycle (state IDLE): accepted.
// - Loads: written only when i_ld_valid && o_ld_ready. Writes while busy are dropped.
//   i_ld_addr >= MAX_INSTRS is dropped. Load and trigger in the same cycle: write
//   first; the run uses the new word.
// - Registers persist across runs; cleared only by reset.
// - Reset mid-run: run abandoned; o_done not asserted; outputs return to 0.
// CONFIGURATION
// - NX_NODE_EXEC_CNT_EN defined: adds output o_exec_count[15:0].
//   - +1 per executed non-NOP instruction; saturates at 16'hFFFF; reset to 0.
// - NX_NODE_EXEC_CNT_EN undefined: port and counter absent; all other behaviour identical.
// TESTING
// - Reset, then trigger with len=0 -> o_done at T+2, o_outputs=8'h00, busy high 1 cycle.
// - Load [0]=AND(in0,in1)->r0, [1]=INVERT(r0)->r1, len=2, i_inputs=8'h03
//   -> at T+4 o_done=1, o_outputs=8'h01; rerun with 8'h01 -> o_outputs=8'h02.
// - Mid-run retrigger and i_ld_valid writes -> trigger ignored, imem unchanged,
//   o_ld_ready=0, single o_done.
// - i_prog_len=40 (MAX_INSTRS=32) -> exactly 32 instrs executed, o_done at T+34.
//   Load to addr 33 -> dropped.
// - rst_n low at EXEC pc=3 -> o_outputs=0, o_busy=0, no o_done.
//   Next run behaves from zeroed regs.
// - NX_NODE_EXEC_CNT_EN: two runs of 2 instrs + 1 NOP -> o_exec_count=4;
//   preload near max -> holds 16'hFFFF.

Source files
------------

// File: rtl/nx_seq_logic_node.sv
// Programmable mesh logic node: runs a loaded list of 2-input boolean instructions over captured inputs.
// Optional feature: define NX_NODE_EXEC_CNT_EN to add the o_exec_count executed-instruction counter.
module nx_seq_logic_node #(
  parameter int NUM_INPUTS  = 8,
  parameter int NUM_OUTPUTS = 8,
  parameter int NUM_REGS    = 16,
  parameter int MAX_INSTRS  = 32,
  localparam int ADDR_W  = $clog2(MAX_INSTRS),
  localparam int SEL_W   = $clog2((NUM_INPUTS > NUM_REGS) ? NUM_INPUTS : NUM_REGS),
  localparam int REG_W   = $clog2(NUM_REGS),
  localparam int INSTR_W = 3 + 2 * (1 + SEL_W) + REG_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_ld_valid,
  input  logic [ADDR_W-1:0]      i_ld_addr,
  input  logic [INSTR_W-1:0]     i_ld_data,
  output logic                   o_ld_ready,
  input  logic [ADDR_W:0]        i_prog_len,
  input  logic                   i_trigger,
  input  logic [NUM_INPUTS-1:0]  i_inputs,
  output logic                   o_busy,
  output logic                   o_done,
  output logic [NUM_OUTPUTS-1:0] o_outputs
`ifdef NX_NODE_EXEC_CNT_EN
  ,
  output logic [15:0]            o_exec_count
`endif
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXEC   = 2'd1,
    COMMIT = 2'd2
  } state_e;

  localparam logic [2:0] OP_INVERT = 3'd0;
  localparam logic [2:0] OP_AND    = 3'd1;
  localparam logic [2:0] OP_NAND   = 3'd2;
  localparam logic [2:0] OP_OR     = 3'd3;
  localparam logic [2:0] OP_NOR    = 3'd4;
  localparam logic [2:0] OP_XOR    = 3'd5;
  localparam logic [2:0] OP_XNOR   = 3'd6;
  localparam logic [2:0] OP_NOP    = 3'd7;

  state_e                  state_q;
  logic [ADDR_W-1:0]       pc_q;
  logic [ADDR_W:0]         len_q;
  logic [NUM_INPUTS-1:0]   inSample_q;
  logic [NUM_REGS-1:0]     regFile_q;
  logic [INSTR_W-1:0]      imem_q [MAX_INSTRS];
  logic [NUM_OUTPUTS-1:0]  outputs_q;
  logic                    done_q;
  logic                    busy_q;
  logic                    ready_q;

  logic [INSTR_W-1:0]      curInstr;
  logic [2:0]              op;
  logic                    isInA;
  logic [SEL_W-1:0]        srcA;
  logic                    isInB;
  logic [SEL_W-1:0]        srcB;
  logic [REG_W-1:0]        tgt;
  logic                    operandA;
  logic                    operandB;
  logic                    result;
  logic                    writeEn;
  logic                    lastInstr;
  logic [ADDR_W:0]         lenClamped;

  assign curInstr = imem_q[pc_q];
  assign {op, isInA, srcA, isInB, srcB, tgt} = curInstr;

  // Selectors past the end of the input or register space read as 0.
  function automatic logic fetchOperand(input logic                  isIn,
                                        input logic [SEL_W-1:0]      src,
                                        input logic [NUM_INPUTS-1:0] ins,
                                        input logic [NUM_REGS-1:0]   regs);
    logic bitVal;
    bitVal = 1'b0;
    if (isIn) begin
      for (int k = 0; k < NUM_INPUTS; k++) begin
        if (src == SEL_W'(k)) bitVal = ins[k];
      end
    end else begin
      for (int k = 0; k < NUM_REGS; k++) begin
        if (src == SEL_W'(k)) bitVal = regs[k];
      end
    end
    return bitVal;
  endfunction

  always_comb begin
    operandA = fetchOperand(isInA, srcA, inSample_q, regFile_q);
    operandB = fetchOperand(isInB, srcB, inSample_q, regFile_q);
    result   = 1'b0;
    writeEn  = 1'b1;
    case (op)
      OP_INVERT: result = ~operandA;
      OP_AND:    result = operandA & operandB;
      OP_NAND:   result = ~(operandA & operandB);
      OP_OR:     result = operandA | operandB;
      OP_NOR:    result = ~(operandA | operandB);
      OP_XOR:    result = operandA ^ operandB;
      OP_XNOR:   result = ~(operandA ^ operandB);
      default:   writeEn = 1'b0;
    endcase
  end

  assign lastInstr  = ({1'b0, pc_q} == (len_q - (ADDR_W+1)'(1)));
  assign lenClamped = (i_prog_len > (ADDR_W+1)'(MAX_INSTRS)) ? (ADDR_W+1)'(MAX_INSTRS) : i_prog_len;

  // Run sequencer; ready/busy are registered from the state being entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pc_q       <= '0;
      len_q      <= '0;
      inSample_q <= '0;
      outputs_q  <= '0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      ready_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
          if (i_trigger) begin
            inSample_q <= i_inputs;
            len_q      <= lenClamped;
            pc_q       <= '0;
            ready_q    <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= (lenClamped == '0) ? COMMIT : EXEC;
          end
        end
        EXEC: begin
          ready_q <= 1'b0;
          busy_q  <= 1'b1;
          if (lastInstr) begin
            state_q <= COMMIT;
          end else begin
            pc_q <= pc_q + ADDR_W'(1);
          end
        end
        COMMIT: begin
          outputs_q <= regFile_q[NUM_OUTPUTS-1:0];
          done_q    <= 1'b1;
          ready_q   <= 1'b1;
          busy_q    <= 1'b0;
          state_q   <= IDLE;
        end
        default: begin
          ready_q <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Addresses beyond the memory depth match no word and are silently dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < MAX_INSTRS; k++) imem_q[k] <= '0;
    end else if (i_ld_valid && ready_q) begin
      for (int k = 0; k < MAX_INSTRS; k++) begin
        if (i_ld_addr == ADDR_W'(k)) imem_q[k] <= i_ld_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regFile_q <= '0;
    end else if (state_q == EXEC && writeEn) begin
      for (int k = 0; k < NUM_REGS; k++) begin
        if (tgt == REG_W'(k)) regFile_q[k] <= result;
      end
    end
  end

`ifdef NX_NODE_EXEC_CNT_EN
  logic [15:0] execCount_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      execCount_q <= '0;
    end else if (state_q == EXEC && op != OP_NOP && execCount_q != 16'hFFFF) begin
      execCount_q <= execCount_q + 16'd1;
    end
  end

  assign o_exec_count = execCount_q;
`endif

  assign o_ld_ready = ready_q;
  assign o_busy     = busy_q;
  assign o_done     = done_q;
  assign o_outputs  = outputs_q;

endmodule

// File: tb/tb_nx_seq_logic_node.sv
// Directed testbench for nx_seq_logic_node: per-op vector table plus multi-cycle run sequences.
module tb_nx_seq_logic_node;

  logic        clk;
  logic        rst_n;
  logic        i_ld_valid;
  logic [4:0]  i_ld_addr;
  logic [16:0] i_ld_data;
  logic        o_ld_ready;
  logic [5:0]  i_prog_len;
  logic        i_trigger;
  logic [7:0]  i_inputs;
  logic        o_busy;
  logic        o_done;
  logic [7:0]  o_outputs;
`ifdef NX_NODE_EXEC_CNT_EN
  logic [15:0] o_exec_count;
`endif

  int compared;
  int mismatched;

  nx_seq_logic_node dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_ld_valid (i_ld_valid),
    .i_ld_addr  (i_ld_addr),
    .i_ld_data  (i_ld_data),
    .o_ld_ready (o_ld_ready),
    .i_prog_len (i_prog_len),
    .i_trigger  (i_trigger),
    .i_inputs   (i_inputs),
    .o_busy     (o_busy),
    .o_done     (o_done),
    .o_outputs  (o_outputs)
`ifdef NX_NODE_EXEC_CNT_EN
    ,
    .o_exec_count (o_exec_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] op;
    logic       isInA;
    logic [3:0] srcA;
    logic       isInB;
    logic [3:0] srcB;
    logic [3:0] tgt;
    logic [7:0] inputs;
    logic [7:0] expOut;
  } vec_t;

  vec_t vecs [11];

  function automatic logic [16:0] mkInstr(input logic [2:0] op, input logic isInA, input logic [3:0] srcA,
                                          input logic isInB, input logic [3:0] srcB, input logic [3:0] tgt);
    return {op, isInA, srcA, isInB, srcB, tgt};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic loadInstr(input logic [4:0] addr, input logic [16:0] data);
    i_ld_valid = 1'b1;
    i_ld_addr  = addr;
    i_ld_data  = data;
    tick();
    i_ld_valid = 1'b0;
  endtask

  // Trigger a run and wait (bounded) for o_done; lat counts cycles after the trigger cycle.
  task automatic applyStimulus(input logic [5:0] len, input logic [7:0] ins, output int lat, output int busyCnt);
    i_prog_len = len;
    i_inputs   = ins;
    i_trigger  = 1'b1;
    tick();
    i_trigger = 1'b0;
    lat       = 1;
    busyCnt   = 0;
    while (!o_done && lat < 200) begin
      if (o_busy) busyCnt++;
      tick();
      lat++;
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lat;
    int busyCnt;
    int doneSeen;

    vecs[0]  = '{3'd0, 1'b1, 4'd0, 1'b1, 4'd1, 4'd0, 8'h00, 8'h01};
    vecs[1]  = '{3'd1, 1'b1, 4'd0, 1'b1, 4'd1, 4'd1, 8'h03, 8'h03};
    vecs[2]  = '{3'd2, 1'b1, 4'd0, 1'b1, 4'd1, 4'd2, 8'h03, 8'h03};
    vecs[3]  = '{3'd3, 1'b1, 4'd0, 1'b1, 4'd1, 4'd3, 8'h02, 8'h0B};
    vecs[4]  = '{3'd4, 1'b1, 4'd0, 1'b1, 4'd1, 4'd4, 8'h00, 8'h1B};
    vecs[5]  = '{3'd5, 1'b1, 4'd0, 1'b1, 4'd1, 4'd5, 8'h01, 8'h3B};
    vecs[6]  = '{3'd6, 1'b1, 4'd0, 1'b1, 4'd1, 4'd6, 8'h01, 8'h3B};
    vecs[7]  = '{3'd7, 1'b1, 4'd0, 1'b1, 4'd1, 4'd0, 8'hFF, 8'h3B};
    vecs[8]  = '{3'd4, 1'b1, 4'd9, 1'b1, 4'd9, 4'd7, 8'hFF, 8'hBB};
    vecs[9]  = '{3'd6, 1'b0, 4'd0, 1'b0, 4'd3, 4'd2, 8'h00, 8'hBF};
    vecs[10] = '{3'd1, 1'b0, 4'd9, 1'b1, 4'd0, 4'd0, 8'hFF, 8'hBE};

    compared   = 0;
    mismatched = 0;
    rst_n      = 1'b0;
    i_ld_valid = 1'b0;
    i_ld_addr  = '0;
    i_ld_data  = '0;
    i_prog_len = '0;
    i_trigger  = 1'b0;
    i_inputs   = '0;

    $display("[TB] reset state");
    tick();
    tick();
    checkOutput("reset_busy", 32'(o_busy), 32'd0);
    checkOutput("reset_done", 32'(o_done), 32'd0);
    checkOutput("reset_outputs", 32'(o_outputs), 32'h00);
    checkOutput("reset_ld_ready", 32'(o_ld_ready), 32'd0);
    rst_n = 1'b1;
    tick();
    checkOutput("ld_ready_after_release", 32'(o_ld_ready), 32'd1);

    $display("[TB] zero-length run");
    applyStimulus(6'd0, 8'hA5, lat, busyCnt);
    checkOutput("len0_latency", 32'(lat), 32'd2);
    checkOutput("len0_busy_cycles", 32'(busyCnt), 32'd1);
    checkOutput("len0_outputs", 32'(o_outputs), 32'h00);

    $display("[TB] AND/INVERT program");
    loadInstr(5'd0, mkInstr(3'd1, 1'b1, 4'd0, 1'b1, 4'd1, 4'd0));
    loadInstr(5'd1, mkInstr(3'd0, 1'b0, 4'd0, 1'b0, 4'd0, 4'd1));
    applyStimulus(6'd2, 8'h03, lat, busyCnt);
    checkOutput("prog2_latency", 32'(lat), 32'd4);
    checkOutput("prog2_busy_cycles", 32'(busyCnt), 32'd3);
    checkOutput("prog2_outputs", 32'(o_outputs), 32'h01);
    // Retrigger issued in the o_done cycle itself.
    applyStimulus(6'd2, 8'h01, lat, busyCnt);
    checkOutput("rerun_latency", 32'(lat), 32'd4);
    checkOutput("rerun_outputs", 32'(o_outputs), 32'h02);

    $display("[TB] retrigger and loads while busy");
    i_prog_len = 6'd2;
    i_inputs   = 8'h03;
    i_trigger  = 1'b1;
    tick();
    checkOutput("busy_ld_ready", 32'(o_ld_ready), 32'd0);
    checkOutput("busy_flag", 32'(o_busy), 32'd1);
    i_ld_valid = 1'b1;
    i_ld_addr  = 5'd0;
    i_ld_data  = mkInstr(3'd0, 1'b1, 4'd0, 1'b1, 4'd0, 4'd0);
    tick();
    tick();
    tick();
    i_trigger  = 1'b0;
    i_ld_valid = 1'b0;
    checkOutput("busy_run_done", 32'(o_done), 32'd1);
    checkOutput("busy_run_outputs", 32'(o_outputs), 32'h01);
    doneSeen = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (o_done) doneSeen++;
    end
    checkOutput("no_queued_trigger", 32'(doneSeen), 32'd0);
    applyStimulus(6'd2, 8'h03, lat, busyCnt);
    checkOutput("imem_unchanged_outputs", 32'(o_outputs), 32'h01);

    $display("[TB] length clamp");
    for (int k = 0; k < 32; k++) loadInstr(5'(k), mkInstr(3'd0, 1'b0, 4'd2, 1'b0, 4'd0, 4'd2));
    applyStimulus(6'd40, 8'h00, lat, busyCnt);
    checkOutput("clamp_latency", 32'(lat), 32'd34);
    checkOutput("clamp_outputs", 32'(o_outputs), 32'h01);

    $display("[TB] reset mid-run");
    i_prog_len = 6'd6;
    i_trigger  = 1'b1;
    tick();
    i_trigger = 1'b0;
    tick();
    tick();
    tick();
    checkOutput("midrun_busy_before_reset", 32'(o_busy), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("midrun_reset_outputs", 32'(o_outputs), 32'h00);
    checkOutput("midrun_reset_busy", 32'(o_busy), 32'd0);
    checkOutput("midrun_reset_done", 32'(o_done), 32'd0);
    tick();
    tick();
    rst_n = 1'b0;
    rst_n = 1'b1;
    doneSeen = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (o_done) doneSeen++;
    end
    checkOutput("midrun_no_done", 32'(doneSeen), 32'd0);
    checkOutput("midrun_idle_busy", 32'(o_busy), 32'd0);
    applyStimulus(6'd1, 8'h00, lat, busyCnt);
    checkOutput("post_reset_latency", 32'(lat), 32'd3);
    checkOutput("post_reset_outputs", 32'(o_outputs), 32'h01);

    $display("[TB] single-op vector table");
    for (int v = 0; v < 11; v++) begin
      loadInstr(5'd0, mkInstr(vecs[v].op, vecs[v].isInA, vecs[v].srcA, vecs[v].isInB, vecs[v].srcB, vecs[v].tgt));
      applyStimulus(6'd1, vecs[v].inputs, lat, busyCnt);
      checkOutput($sformatf("vec%0d_latency", v), 32'(lat), 32'd3);
      checkOutput($sformatf("vec%0d_outputs", v), 32'(o_outputs), 32'(vecs[v].expOut));
    end

`ifdef NX_NODE_EXEC_CNT_EN
    $display("[TB] executed-instruction counter");
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    loadInstr(5'd0, mkInstr(3'd1, 1'b1, 4'd0, 1'b1, 4'd1, 4'd0));
    loadInstr(5'd1, mkInstr(3'd0, 1'b0, 4'd0, 1'b0, 4'd0, 4'd1));
    loadInstr(5'd2, mkInstr(3'd7, 1'b0, 4'd0, 1'b0, 4'd0, 4'd0));
    applyStimulus(6'd3, 8'h03, lat, busyCnt);
    applyStimulus(6'd3, 8'h03, lat, busyCnt);
    checkOutput("exec_count", 32'(o_exec_count), 32'd4);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
